// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS decode constants, ALU codes and control bundle
package mips_pkg;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_PASS = 3'b101,
      ALU_SUB  = 3'b110,
      ALU_SLT  = 3'b111
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_t;

   // Operand2 source; SRC_JUMP also redirects operand1 to the jump target.
   typedef enum logic [1:0] {
      SRC_RT   = 2'd0,
      SRC_SEXT = 2'd1,
      SRC_ZEXT = 2'd2,
      SRC_JUMP = 2'd3
   } b_sel_t;

   typedef enum logic [1:0] {
      DST_NONE = 2'd0,
      DST_RT   = 2'd1,
      DST_RD   = 2'd2
   } dst_sel_t;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - opcode/funct to ALU code, operand select and control bundle
module alu_op_decoder
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_op_t    alu_op,
   output b_sel_t     b_sel,
   output dst_sel_t   dst_sel,
   output ctrl_t      ctrl,
   output logic       store,
   output logic       illegal
);

   always_comb begin
      alu_op  = ALU_AND;
      b_sel   = SRC_RT;
      dst_sel = DST_NONE;
      ctrl    = '0;
      store   = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dst_sel        = DST_RD;
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_SLT:  alu_op = ALU_SLT;
               default: begin
                  illegal = 1'b1;
                  dst_sel = DST_NONE;
                  ctrl    = '0;
               end
            endcase
         end
         OP_ADDI: begin
            alu_op = ALU_ADD; b_sel = SRC_SEXT; dst_sel = DST_RT; ctrl.reg_write = 1'b1;
         end
         OP_ANDI: begin
            alu_op = ALU_AND; b_sel = SRC_ZEXT; dst_sel = DST_RT; ctrl.reg_write = 1'b1;
         end
         OP_ORI: begin
            alu_op = ALU_OR; b_sel = SRC_ZEXT; dst_sel = DST_RT; ctrl.reg_write = 1'b1;
         end
         OP_SLTI: begin
            alu_op = ALU_SLT; b_sel = SRC_SEXT; dst_sel = DST_RT; ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            alu_op = ALU_ADD; b_sel = SRC_SEXT; dst_sel = DST_RT;
            ctrl.reg_write = 1'b1;
            ctrl.mem_read  = 1'b1;
         end
         OP_SW: begin
            alu_op = ALU_ADD; b_sel = SRC_SEXT; store = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            alu_op = ALU_SUB; ctrl.branch = 1'b1;
         end
         OP_J: begin
            alu_op = ALU_PASS; b_sel = SRC_JUMP;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_alu_issue.sv
// rtl/id_ex_alu_issue.sv - ID/EX issue register feeding the EX ALU; ID_EX_FORWARD_EN adds EX/MEM and MEM/WB bypass
module id_ex_alu_issue
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [31:0]   instr,
   input  logic [DW-1:0] rs_data,
   input  logic [DW-1:0] rt_data,
   input  logic          stall,
   input  logic          flush,
`ifdef ID_EX_FORWARD_EN
   input  logic          exm_wr,
   input  logic [RW-1:0] exm_reg,
   input  logic [DW-1:0] exm_data,
   input  logic          wb_wr,
   input  logic [RW-1:0] wb_reg,
   input  logic [DW-1:0] wb_data,
`endif
   output logic          ex_valid,
   output logic [2:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [DW-1:0] store_data,
   output logic [RW-1:0] dest_reg,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic          branch,
   output logic          illegal
);

   alu_op_t  dec_op;
   b_sel_t   dec_bsel;
   dst_sel_t dec_dst;
   ctrl_t    dec_ctrl;
   logic     dec_store;
   logic     dec_illegal;

   alu_op_decoder u_dec (
      .opcode  (instr[31:26]),
      .funct   (instr[5:0]),
      .alu_op  (dec_op),
      .b_sel   (dec_bsel),
      .dst_sel (dec_dst),
      .ctrl    (dec_ctrl),
      .store   (dec_store),
      .illegal (dec_illegal)
   );

   logic [RW-1:0] rs_spec, rt_spec;
   logic [DW-1:0] rs_val, rt_val;
   logic [DW-1:0] a_nxt, b_nxt, sd_nxt;
   logic [RW-1:0] dest_nxt;
   ctrl_t         ctrl_nxt, ctrl_q;

   assign rs_spec = RW'(instr[25:21]);
   assign rt_spec = RW'(instr[20:16]);

   // EX/MEM is younger than MEM/WB, so it wins when both match.
   always_comb begin
      rs_val = rs_data;
      rt_val = rt_data;
`ifdef ID_EX_FORWARD_EN
      if (exm_wr && (exm_reg != '0) && (exm_reg == rs_spec))
         rs_val = exm_data;
      else if (wb_wr && (wb_reg != '0) && (wb_reg == rs_spec))
         rs_val = wb_data;
      if (exm_wr && (exm_reg != '0) && (exm_reg == rt_spec))
         rt_val = exm_data;
      else if (wb_wr && (wb_reg != '0) && (wb_reg == rt_spec))
         rt_val = wb_data;
`endif
   end

   always_comb begin
      a_nxt = rs_val;
      case (dec_bsel)
         SRC_SEXT: b_nxt = {{(DW-16){instr[15]}}, instr[15:0]};
         SRC_ZEXT: b_nxt = {{(DW-16){1'b0}}, instr[15:0]};
         SRC_JUMP: begin
            a_nxt = {{(DW-26){1'b0}}, instr[25:0]};
            b_nxt = '0;
         end
         default:  b_nxt = rt_val;
      endcase
      case (dec_dst)
         DST_RT:  dest_nxt = rt_spec;
         DST_RD:  dest_nxt = RW'(instr[15:11]);
         default: dest_nxt = '0;
      endcase
      ctrl_nxt = dec_ctrl;
      // A write to $0 is architecturally discarded, so never announce one.
      if (dest_nxt == '0)
         ctrl_nxt.reg_write = 1'b0;
      sd_nxt = dec_store ? rt_val : '0;
   end

   logic load_bubble, load_instr;
   assign load_bubble = flush || (!stall && (!in_valid || dec_illegal));
   assign load_instr  = !flush && !stall && in_valid && !dec_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         alu_op     <= ALU_AND;
         alu_a      <= '0;
         alu_b      <= '0;
         store_data <= '0;
         dest_reg   <= '0;
         ctrl_q     <= '0;
         illegal    <= 1'b0;
      end else begin
         if (load_bubble) begin
            ex_valid   <= 1'b0;
            alu_op     <= ALU_AND;
            alu_a      <= '0;
            alu_b      <= '0;
            store_data <= '0;
            dest_reg   <= '0;
            ctrl_q     <= '0;
         end else if (load_instr) begin
            ex_valid   <= 1'b1;
            alu_op     <= dec_op;
            alu_a      <= a_nxt;
            alu_b      <= b_nxt;
            store_data <= sd_nxt;
            dest_reg   <= dest_nxt;
            ctrl_q     <= ctrl_nxt;
         end
         if (!flush && !stall && in_valid && dec_illegal)
            illegal <= 1'b1;
      end
   end

   assign reg_write = ctrl_q.reg_write;
   assign mem_read  = ctrl_q.mem_read;
   assign mem_write = ctrl_q.mem_write;
   assign branch    = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb/tb_id_ex_alu_issue.sv - scoreboard bench for id_ex_alu_issue
module tb_id_ex_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
`ifdef ID_EX_FORWARD_EN
   logic        exm_wr = 1'b0;
   logic [4:0]  exm_reg = '0;
   logic [31:0] exm_data = '0;
   logic        wb_wr = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
`endif
   logic        ex_valid, reg_write, mem_read, mem_write, branch, illegal;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, store_data;
   logic [4:0]  dest_reg;

   id_ex_alu_issue #(.DW(32), .RW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .instr      (instr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .stall      (stall),
      .flush      (flush),
`ifdef ID_EX_FORWARD_EN
      .exm_wr     (exm_wr),
      .exm_reg    (exm_reg),
      .exm_data   (exm_data),
      .wb_wr      (wb_wr),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
`endif
      .ex_valid   (ex_valid),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .store_data (store_data),
      .dest_reg   (dest_reg),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        ill;
   } out_t;

   typedef struct packed {
      logic        v;
      logic        st;
      logic        fl;
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      out_t        exp;
   } stim_t;

   out_t obs;
   assign obs = {ex_valid, alu_op, alu_a, alu_b, store_data, dest_reg,
                 reg_write, mem_read, mem_write, branch, illegal};

   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam out_t BUBBLE = '0;

   function automatic out_t mk(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] sd, input logic [4:0] d,
                               input logic rw, input logic mr, input logic mw, input logic br,
                               input logic ill);
      out_t o;
      o = {v, op, a, b, sd, d, rw, mr, mw, br, ill};
      return o;
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic stim_t mks(input logic v, input logic st, input logic fl, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic [31:0] rt, input out_t exp);
      stim_t s;
      s = {v, st, fl, ins, rs, rt, exp};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      @(negedge clk);
      in_valid = s.v;
      stall    = s.st;
      flush    = s.fl;
      instr    = s.ins;
      rs_data  = s.rs;
      rt_data  = s.rt;
   endtask

   task automatic test_reset_state;
      out_t got;
      #1;
      sb.push_back(BUBBLE);
      got = sb.pop_front();
      checks++;
      if (obs !== got) begin
         errors++;
         $display("FAIL reset_state: actual %h required %h", obs, got);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rtype;
      stim_t t[$];
      out_t  got;
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7,
                      mk(1, 3'b010, 5, 7, 0, 3, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, rtype(6, 7, 5, 6'b100010), 20, 3,
                      mk(1, 3'b110, 20, 3, 0, 5, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, rtype(1, 2, 8, 6'b100100), 32'h0000F0F0, 32'h00000FF0,
                      mk(1, 3'b000, 32'h0000F0F0, 32'h00000FF0, 0, 8, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, rtype(1, 2, 9, 6'b100101), 32'h12340000, 32'h00005678,
                      mk(1, 3'b001, 32'h12340000, 32'h00005678, 0, 9, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, rtype(1, 2, 10, 6'b101010), 32'hFFFFFFFF, 1,
                      mk(1, 3'b111, 32'hFFFFFFFF, 1, 0, 10, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, rtype(1, 2, 0, 6'b100000), 5, 7,
                      mk(1, 3'b010, 5, 7, 0, 0, 0, 0, 0, 0, 0)));
      foreach (t[i]) begin
         drive(t[i]);
         sb.push_back(t[i].exp);
         @(posedge clk); #1;
         got = sb.pop_front();
         checks++;
         if (obs !== got) begin
            errors++;
            $display("FAIL rtype[%0d]: actual %h required %h", i, obs, got);
         end
      end
   endtask

   task automatic test_imm;
      stim_t t[$];
      out_t  got;
      t.push_back(mks(1, 0, 0, itype(6'b001000, 1, 4, 16'hFFFF), 10, 99,
                      mk(1, 3'b010, 10, 32'hFFFFFFFF, 0, 4, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, itype(6'b001100, 1, 4, 16'hFFFF), 10, 99,
                      mk(1, 3'b000, 10, 32'h0000FFFF, 0, 4, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, itype(6'b001101, 2, 6, 16'h8001), 1, 99,
                      mk(1, 3'b001, 1, 32'h00008001, 0, 6, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, itype(6'b001010, 3, 7, 16'h8000), 2, 99,
                      mk(1, 3'b111, 2, 32'hFFFF8000, 0, 7, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, itype(6'b001000, 3, 7, 16'h7FFF), 2, 99,
                      mk(1, 3'b010, 2, 32'h00007FFF, 0, 7, 1, 0, 0, 0, 0)));
      t.push_back(mks(1, 0, 0, itype(6'b000100, 1, 2, 16'h0004), 3, 3,
                      mk(1, 3'b110, 3, 3, 0, 0, 0, 0, 0, 1, 0)));
      t.push_back(mks(1, 0, 0, {6'b000010, 26'h3FFFFFF}, 32'h55, 32'h66,
                      mk(1, 3'b101, 32'h03FFFFFF, 0, 0, 0, 0, 0, 0, 0, 0)));
      foreach (t[i]) begin
         drive(t[i]);
         sb.push_back(t[i].exp);
         @(posedge clk); #1;
         got = sb.pop_front();
         checks++;
         if (obs !== got) begin
            errors++;
            $display("FAIL imm[%0d]: actual %h required %h", i, obs, got);
         end
      end
   endtask

   task automatic test_stall_flush;
      stim_t t[$];
      out_t  got;
      out_t  lw_exp;
      lw_exp = mk(1, 3'b010, 100, 16, 0, 8, 1, 1, 0, 0, 0);
      t.push_back(mks(1, 0, 0, itype(6'b100011, 9, 8, 16'h0010), 100, 77, lw_exp));
      for (int k = 0; k < 3; k++)
         t.push_back(mks(1, 1, 0, rtype(1, 2, 3, 6'b100000), 200 + k, 300 + k, lw_exp));
      t.push_back(mks(1, 1, 1, rtype(1, 2, 3, 6'b100000), 5, 7, BUBBLE));
      t.push_back(mks(1, 0, 0, itype(6'b100011, 9, 8, 16'h0010), 100, 77, lw_exp));
      t.push_back(mks(0, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7, BUBBLE));
      t.push_back(mks(1, 0, 1, rtype(1, 2, 3, 6'b100000), 5, 7, BUBBLE));
      foreach (t[i]) begin
         drive(t[i]);
         sb.push_back(t[i].exp);
         @(posedge clk); #1;
         got = sb.pop_front();
         checks++;
         if (obs !== got) begin
            errors++;
            $display("FAIL stall_flush[%0d]: actual %h required %h", i, obs, got);
         end
      end
   endtask

`ifdef ID_EX_FORWARD_EN
   task automatic test_forward;
      stim_t t[$];
      out_t  got;
      logic [4:0]  ereg[$];
      logic [4:0]  wreg[$];
      logic        ewr[$];
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7,
                      mk(1, 3'b010, 9, 7, 0, 3, 1, 0, 0, 0, 0)));
      ewr.push_back(1); ereg.push_back(1); wreg.push_back(1);
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7,
                      mk(1, 3'b010, 4, 7, 0, 3, 1, 0, 0, 0, 0)));
      ewr.push_back(1); ereg.push_back(0); wreg.push_back(1);
      t.push_back(mks(1, 0, 0, rtype(0, 2, 3, 6'b100000), 5, 7,
                      mk(1, 3'b010, 5, 7, 0, 3, 1, 0, 0, 0, 0)));
      ewr.push_back(1); ereg.push_back(0); wreg.push_back(0);
      t.push_back(mks(1, 0, 0, itype(6'b101011, 1, 2, 16'h0000), 5, 7,
                      mk(1, 3'b010, 9, 0, 4, 0, 0, 0, 1, 0, 0)));
      ewr.push_back(1); ereg.push_back(1); wreg.push_back(2);
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7,
                      mk(1, 3'b010, 5, 4, 0, 3, 1, 0, 0, 0, 0)));
      ewr.push_back(0); ereg.push_back(1); wreg.push_back(2);
      exm_data = 9;
      wb_data  = 4;
      wb_wr    = 1'b1;
      foreach (t[i]) begin
         drive(t[i]);
         exm_wr  = ewr[i];
         exm_reg = ereg[i];
         wb_reg  = wreg[i];
         sb.push_back(t[i].exp);
         @(posedge clk); #1;
         got = sb.pop_front();
         checks++;
         if (obs !== got) begin
            errors++;
            $display("FAIL forward[%0d]: actual %h required %h", i, obs, got);
         end
      end
      @(negedge clk);
      exm_wr = 1'b0;
      wb_wr  = 1'b0;
   endtask
`endif

   task automatic test_illegal;
      stim_t t[$];
      out_t  got;
      out_t  add_exp;
      add_exp = mk(1, 3'b010, 5, 7, 0, 3, 1, 0, 0, 0, 0);
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b100000), 5, 7, add_exp));
      t.push_back(mks(1, 1, 0, {6'b111111, 26'h0}, 5, 7, add_exp));
      t.push_back(mks(1, 0, 1, {6'b111111, 26'h0}, 5, 7, BUBBLE));
      t.push_back(mks(1, 0, 0, {6'b111111, 26'h0}, 5, 7,
                      mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      t.push_back(mks(1, 0, 0, itype(6'b101011, 1, 2, 16'h0008), 32'h1000, 32'hABCD,
                      mk(1, 3'b010, 32'h1000, 8, 32'hABCD, 0, 0, 0, 1, 0, 1)));
      t.push_back(mks(1, 0, 0, rtype(1, 2, 3, 6'b000111), 5, 7,
                      mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      t.push_back(mks(0, 0, 0, 32'h0, 0, 0,
                      mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      foreach (t[i]) begin
         drive(t[i]);
         sb.push_back(t[i].exp);
         @(posedge clk); #1;
         got = sb.pop_front();
         checks++;
         if (obs !== got) begin
            errors++;
            $display("FAIL illegal[%0d]: actual %h required %h", i, obs, got);
         end
      end
   endtask

   task automatic test_reset_mid_stall;
      stim_t s;
      out_t  got;
      s = mks(1, 0, 0, itype(6'b100011, 9, 8, 16'h0010), 100, 77,
              mk(1, 3'b010, 100, 16, 0, 8, 1, 1, 0, 0, 1));
      drive(s);
      sb.push_back(s.exp);
      @(posedge clk); #1;
      got = sb.pop_front();
      checks++;
      if (obs !== got) begin
         errors++;
         $display("FAIL reset_preload: actual %h required %h", obs, got);
      end
      @(negedge clk);
      stall = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      sb.push_back(BUBBLE);
      got = sb.pop_front();
      checks++;
      if (obs !== got) begin
         errors++;
         $display("FAIL reset_async: actual %h required %h", obs, got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      in_valid = 1'b0;
      sb.push_back(BUBBLE);
      @(posedge clk); #1;
      got = sb.pop_front();
      checks++;
      if (obs !== got) begin
         errors++;
         $display("FAIL reset_release: actual %h required %h", obs, got);
      end
   endtask

   initial begin
      test_reset_state();
      test_rtype();
      test_imm();
      test_stall_flush();
`ifdef ID_EX_FORWARD_EN
      test_forward();
`endif
      test_illegal();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
